// File: rtl/rv_arb_pkg.sv
// Shared types and the round-robin pick function for rv_reg_arbiter and
// future arbiters built on the same picker.
package rv_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // The picker is written for the widest supported requester count and
  // narrower instances zero-pad their inputs.
  localparam int MAXREQ = 8;
  localparam int PTRW   = 3;

  typedef struct packed {
    logic            found;
    logic [PTRW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... modulo nreq; ptr < nreq.
  function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                       input logic [PTRW-1:0]   ptr,
                                       input int                nreq);
    rr_pick_t r;
    int       cand;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MAXREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= nreq) cand = cand - nreq;
      if ((k < nreq) && !r.found && valid[cand[PTRW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[PTRW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_reg_arbiter_rr_select.sv
// rr_select: combinational round-robin picker over NREQ requesters,
// starting the search at ptr_i and wrapping modulo NREQ.
module rr_select #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o
);
  import rv_arb_pkg::*;

  logic [MAXREQ-1:0] valid_ext;
  logic [PTRW-1:0]   ptr_ext;
  rr_pick_t          pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid_i;
    ptr_ext               = PTRW'(ptr_i);
    pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
    found_o               = pick.found;
    idx_o                 = IDW'(pick.idx);
  end

endmodule

// File: rtl/rv_reg_arbiter.sv
// rv_reg_arbiter: round-robin arbiter sharing one external mod_register slot
// between NREQ producers and one consumer. RV_REG_ARB_LOCK_EN adds burst locking.
module rv_reg_arbiter
  import rv_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
`ifdef RV_REG_ARB_LOCK_EN
  ,
  parameter int MAXBURST = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      reg_in,
  output logic                  reg_en,
  input  logic [WIDTH-1:0]      reg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output arb_state_e            dbg_state,
  output logic [IDW-1:0]        dbg_ptr
);

  // Handshake: a producer transfer happens on an edge where req_valid[i] and
  // req_ready[i] are both high; the consumer transfer happens on an edge where
  // out_valid and out_ready are both high. Both may occur on the same edge.

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           free;
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  logic           grant;
  logic [IDW-1:0] gnt_idx;

  rr_select #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_select (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  // The slot can be refilled when empty or when it is draining this cycle.
  assign free = !rst && ((state_q == EMPTY) || out_ready);

`ifdef RV_REG_ARB_LOCK_EN
  localparam int CNTW = $clog2(MAXBURST + 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            lock_hit;

  // cnt_q == 0 means no burst is open (after reset nothing has been granted).
  assign lock_hit = (cnt_q != '0) && req_valid[id_q] && (cnt_q < CNTW'(MAXBURST));
  assign grant    = free && (lock_hit || rr_found);
  assign gnt_idx  = lock_hit ? id_q : rr_idx;
`else
  assign grant   = free && rr_found;
  assign gnt_idx = rr_idx;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    req_ready = '0;
    reg_en    = 1'b0;
    reg_in    = '0;
`ifdef RV_REG_ARB_LOCK_EN
    cnt_d     = cnt_q;
`endif
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
      reg_en             = 1'b1;
      reg_in             = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
      state_d            = FULL;
      id_d               = gnt_idx;
`ifdef RV_REG_ARB_LOCK_EN
      if (lock_hit) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = CNTW'(1);
        ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
`else
      ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
`endif
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
`ifdef RV_REG_ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
`ifdef RV_REG_ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = reg_data;
  assign out_id    = id_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rv_reg_arbiter.sv
// Self-checking bench for rv_reg_arbiter: a behavioural mod_register, a
// vector table, hand-written corner sequences and a randomized phase.
module tb_rv_reg_arbiter;
  import rv_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;
  localparam int QW    = IDW + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data  = '0;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      reg_in;
  logic                  reg_en;
  logic [WIDTH-1:0]      reg_q;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  arb_state_e            dbg_state;
  logic [IDW-1:0]        dbg_ptr;

  // External storage slot, reset by its own rst.
  always @(posedge clk) begin
    if (rst) reg_q <= '0;
    else if (reg_en) reg_q <= reg_in;
  end

  rv_reg_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
`ifdef RV_REG_ARB_LOCK_EN
    ,
    .MAXBURST (2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_in    (reg_in),
    .reg_en    (reg_en),
    .reg_data  (reg_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [QW-1:0] exp_q[$];
  logic exp_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at negedge, check combinational outputs, then check the
  // registered state #1 after the following posedge.
  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic o,
                      input logic [NREQ*WIDTH-1:0] d, input logic [NREQ-1:0] e_rdy,
                      input logic e_ov, input logic [IDW-1:0] e_id, input logic [IDW-1:0] e_ptr);
    logic [QW-1:0]    head;
    logic [WIDTH-1:0] gd;
    int               g;
    @(negedge clk);
    rst = r; req_valid = v; out_ready = o; req_data = d;
    #1;
    g  = -1;
    gd = '0;
    for (int i = 0; i < NREQ; i++) if (e_rdy[i]) g = i;
    if (g >= 0) gd = d[g*WIDTH +: WIDTH];
    check("req_ready", 64'(req_ready), 64'(e_rdy));
    check("reg_en", 64'(reg_en), 64'(e_rdy != '0));
    check("reg_in", 64'(reg_in), 64'(gd));
    check("out_valid", 64'(out_valid), 64'(exp_full));
    if (exp_full) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: got empty queue expected an entry (t=%0t)", $time);
      end else begin
        head = exp_q[0];
        check("out_data", 64'(out_data), 64'(head[WIDTH-1:0]));
        check("out_id", 64'(out_id), 64'(head[QW-1:WIDTH]));
        if (o && !r) void'(exp_q.pop_front());
      end
    end
    if (g >= 0) exp_q.push_back({IDW'(g), gd});
    @(posedge clk);
    #1;
    if (r) exp_q.delete();
    exp_full = e_ov;
    check("out_valid_next", 64'(out_valid), 64'(e_ov));
    check("out_id_next", 64'(out_id), 64'(e_id));
    check("ptr_next", 64'(dbg_ptr), 64'(e_ptr));
    if (e_ov && exp_q.size() != 0) check("out_data_next", 64'(out_data), 64'(exp_q[0][WIDTH-1:0]));
  endtask

  function automatic logic [NREQ*WIDTH-1:0] row_data(input int k);
    logic [NREQ*WIDTH-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'(16'h0A00 + i * 16'h1000 + k);
    return d;
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic            r;
    logic [NREQ-1:0] v;
    logic            o;
    logic [NREQ-1:0] rdy;
    logic            ov;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  ptr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [NREQ*WIDTH-1:0] cur;
    logic [NREQ-1:0]       v, rdy;
    logic                  o, m_full;
    logic [IDW-1:0]        m_ptr, m_id;
    int                    g, idx;

    // Reset held with all requesters valid, then fairness, drain, skip/wrap.
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd3};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1};
    tbl[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd3};
    tbl[9]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    tbl[10] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd0};
    tbl[11] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1};

`ifdef RV_REG_ARB_LOCK_EN
    for (int k = 0; k < 2; k++)
      step(tbl[k].r, tbl[k].v, tbl[k].o, row_data(k), tbl[k].rdy, tbl[k].ov, tbl[k].id, tbl[k].ptr);
    // MAXBURST=2 with requesters 0 and 1 held valid: grants 0,0,1,1,0,0.
    step(1'b0, 4'b0011, 1'b1, row_data(20), 4'b0001, 1'b1, 2'd0, 2'd1);
    step(1'b0, 4'b0011, 1'b1, row_data(21), 4'b0001, 1'b1, 2'd0, 2'd1);
    step(1'b0, 4'b0011, 1'b1, row_data(22), 4'b0010, 1'b1, 2'd1, 2'd2);
    step(1'b0, 4'b0011, 1'b1, row_data(23), 4'b0010, 1'b1, 2'd1, 2'd2);
    step(1'b0, 4'b0011, 1'b1, row_data(24), 4'b0001, 1'b1, 2'd0, 2'd1);
    step(1'b0, 4'b0011, 1'b1, row_data(25), 4'b0001, 1'b1, 2'd0, 2'd1);
    step(1'b0, 4'b0000, 1'b1, row_data(26), 4'b0000, 1'b0, 2'd0, 2'd1);
`else
    for (int k = 0; k < 13; k++)
      step(tbl[k].r, tbl[k].v, tbl[k].o, row_data(k), tbl[k].rdy, tbl[k].ov, tbl[k].id, tbl[k].ptr);

    // Backpressure: requester 2 with BEEF, held for 5 stalled cycles, then drained.
    cur = '0;
    cur[2*WIDTH +: WIDTH] = 16'hBEEF;
    step(1'b0, 4'b0100, 1'b0, cur, 4'b0100, 1'b1, 2'd2, 2'd3);
    for (int k = 0; k < 5; k++)
      step(1'b0, 4'b0100, 1'b0, cur, 4'b0000, 1'b1, 2'd2, 2'd3);
    step(1'b0, 4'b0000, 1'b1, cur, 4'b0000, 1'b0, 2'd2, 2'd3);

    // Mid-operation reset with the slot full and out_id=2.
    cur[2*WIDTH +: WIDTH] = 16'h5A5A;
    step(1'b0, 4'b0100, 1'b0, cur, 4'b0100, 1'b1, 2'd2, 2'd3);
    step(1'b1, 4'b0100, 1'b0, cur, 4'b0000, 1'b0, 2'd0, 2'd0);
    step(1'b0, 4'b0000, 1'b0, cur, 4'b0000, 1'b0, 2'd0, 2'd0);
    step(1'b0, 4'b1111, 1'b0, row_data(40), 4'b0001, 1'b1, 2'd0, 2'd1);
    step(1'b0, 4'b0000, 1'b1, row_data(41), 4'b0000, 1'b0, 2'd0, 2'd1);

    // Randomized phase against a small reference model.
    step(1'b1, 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 2'd0, 2'd0);
    m_full = 1'b0; m_ptr = '0; m_id = '0;
    for (int i = 0; i < NREQ; i++) cur[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
    for (int n = 0; n < 200; n++) begin
      v   = NREQ'($urandom_range(0, 15));
      o   = ($urandom_range(0, 3) != 0);
      rdy = '0;
      g   = -1;
      if (!m_full || o) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (int'(m_ptr) + k) % NREQ;
          if (g < 0 && v[idx]) g = idx;
        end
      end
      if (g >= 0) begin
        rdy[g] = 1'b1;
        m_full = 1'b1;
        m_id   = IDW'(g);
        m_ptr  = IDW'((g + 1) % NREQ);
      end else if (m_full && o) begin
        m_full = 1'b0;
      end
      step(1'b0, v, o, cur, rdy, m_full, m_id, m_ptr);
      if (g >= 0) cur[g*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_reg_arbiter.md
Name: rv_reg_arbiter

Overview:
- Round-robin arbiter that shares one external mod_register slot between NREQ ready/valid producers and one ready/valid consumer.
- It drives the register's in/en pins and tracks occupancy, the same way rvc drives a ready register.
- It sits between several producer stages and one downstream stage, replacing per-producer rvc instances where a single storage slot is shared.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, payload width; must match the external mod_register WIDTH
- IDW, 2, width of out_id; must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester valid
- req_data  in  NREQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  per-requester ready, one-hot or zero
- reg_in  out  WIDTH  data to the external mod_register .in
- reg_en  out  1  write enable to the external mod_register .en
- reg_data  in  WIDTH  external mod_register .data
- out_valid  out  1  slot holds valid data
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  equals reg_data
- out_id  out  IDW  index of the requester whose data is in the slot

Behaviour:
- State FULL (1 bit) plus ptr (IDW bits).
- Reset values: FULL=0, ptr=0, out_id=0. Consequently out_valid=0 and reg_en=0. req_ready=0 while rst=1.
- Free slot: free = !FULL | (FULL & out_ready). Same-cycle drain and refill is allowed, giving 1 item per cycle of throughput.
- Grant: when free, grant goes to the first i with req_valid[i] set, scanning ptr, ptr+1, ... modulo NREQ. At most one grant per cycle.
- req_ready = grant (one-hot). It is combinational from req_valid, FULL, out_ready and ptr.
- No valid requester: req_ready=0.
- On grant to requester g:
  - reg_in = req_data[g], reg_en=1.
  - On the next edge: FULL=1, out_id=g, ptr=(g+1) mod NREQ.
- When there is no grant: reg_en=0 and reg_in=0.
- Drain without refill (FULL & out_ready & no grant): FULL=0 on the next edge. ptr is unchanged.
- Latency: a transfer accepted at edge N appears as out_valid/out_data at edge N (register output updates at that edge). Minimum input-to-output latency is 1 cycle.
- out_valid=FULL. out_data=reg_data. out_data is held stable while out_valid & !out_ready.
- Requesters must hold req_valid and req_data until req_ready; the arbiter does not check this.
- Wrap: ptr increments modulo NREQ even when NREQ is not a power of 2 (e.g. ptr at NREQ-1 goes to 0).
- Reset mid-operation: FULL cleared and pending data discarded; ptr and out_id go to 0. The register is cleared by its own rst.
- When !FULL, out_ready is ignored.

Optional Feature:
- Macro RV_REG_ARB_LOCK_EN.
- Defined:
  - Adds parameter MAXBURST (default 4) and a burst counter.
  - After granting g, the next grant goes to g again while req_valid[g]=1 and the burst count < MAXBURST. ptr is not advanced in that case.
  - When g drops valid or hits MAXBURST, the counter resets and normal round-robin resumes from g+1.
- Undefined: strict round-robin every grant; no counter logic is present.

Decomposition:
- Package rv_arb_pkg: state encoding (EMPTY=0, FULL=1) and a function rr_pick(valid, ptr) returning the index and a found bit.
- One sub-module is natural: rr_select (combinational round-robin picker, NREQ and IDW parameters), reused by future arbiters.
- Storage stays in the external mod_register; it is not instantiated inside the arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=4'b1111 → req_ready=0, reg_en=0, out_valid=0; after release, first grant goes to requester 0.
- Fairness: req_valid=4'b1111 continuously, out_ready=1 → out_id sequence 0,1,2,3,0 on consecutive cycles, one transfer per cycle.
- Backpressure: req_valid=4'b0100, data 16'hBEEF, out_ready=0 → out_valid=1, out_id=2, out_data=16'hBEEF held for 5 cycles; req_ready=0 throughout; out_ready=1 → drains, FULL=0.
- Skip/wrap: ptr=3, req_valid=4'b0010 → grant 1, then ptr=2; next req_valid=4'b1001 → grant 3, then grant 0.
- Mid-operation reset: FULL=1, out_id=2, pulse rst for 1 cycle → out_valid=0, out_id=0, ptr=0 next cycle.
- Lock (RV_REG_ARB_LOCK_EN, MAXBURST=2): req_valid=4'b0011 held → grants 0,0,1,1,0,0.
